// File: rtl/adc_sample_ctrl_pkg.sv
// Shared types and default constants for the ADC sampling sequencer.
package adc_sample_ctrl_pkg;

  localparam int ADC_W = 8;

  localparam int DEFAULT_DIV       = 500;
  localparam int DEFAULT_SETTLE    = 2;
  localparam int DEFAULT_AVG_LOG2  = 2;
  localparam logic [ADC_W-1:0] DEFAULT_ACTIVE_TH = 8'd100;
  localparam logic [ADC_W-1:0] DEFAULT_REST_TH   = 8'd60;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CONV,
    ST_WAIT,
    ST_SAMPLE,
    ST_PUBLISH
  } state_e;

endpackage

// File: rtl/sample_tick_div.sv
// Sample-rate divider: counts 0..DIV-1 while enabled and pulses tick on wrap.
module sample_tick_div #(
  parameter int DIV = 500
) (
  input  logic clock,
  input  logic ctrl_reset_n,
  input  logic enable,
  output logic tick
);

  localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(DIV - 1);

  logic [CW-1:0] count_q, count_d;

  // Dropping enable restarts the sample period from zero.
  always_comb begin
    count_d = count_q;
    tick    = 1'b0;
    if (!enable) begin
      count_d = '0;
    end else if (count_q == LAST) begin
      count_d = '0;
      tick    = 1'b1;
    end else begin
      count_d = count_q + 1'b1;
    end
  end

  always_ff @(posedge clock) begin
    if (!ctrl_reset_n) count_q <= '0;
    else               count_q <= count_d;
  end

endmodule

// File: rtl/adc_sample_ctrl.sv
// ADC sequencer: paces conversions, averages 2^AVG_LOG2 samples, publishes with
// a ready/ack handshake and derives rest/active status with hysteresis.
module adc_sample_ctrl
  import adc_sample_ctrl_pkg::*;
#(
  parameter int DIV      = DEFAULT_DIV,
  parameter int SETTLE   = DEFAULT_SETTLE,
  parameter int AVG_LOG2 = DEFAULT_AVG_LOG2,
  parameter logic [ADC_W-1:0] ACTIVE_TH = DEFAULT_ACTIVE_TH,
  parameter logic [ADC_W-1:0] REST_TH   = DEFAULT_REST_TH
) (
  input  logic             clock,
  input  logic             ctrl_reset_n,
  input  logic             enable,
  input  logic [ADC_W-1:0] adc_in,
  input  logic             ack,
  output logic             adc_conv,
  output logic [ADC_W-1:0] sample_out,
  output logic             sample_ready,
  output logic             rest,
  output logic             active,
  output logic             overrun
);

  localparam int ACC_W = ADC_W + AVG_LOG2;
  localparam int CNT_W = (AVG_LOG2 > 0) ? AVG_LOG2 : 1;
  localparam int WCW   = (SETTLE > 1) ? $clog2(SETTLE) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX   = CNT_W'((1 << AVG_LOG2) - 1);
  localparam logic [WCW-1:0]   WAIT_LAST = WCW'((SETTLE > 0) ? SETTLE - 1 : 0);

  logic tick;

  sample_tick_div #(.DIV(DIV)) u_tick_div (
    .clock        (clock),
    .ctrl_reset_n (ctrl_reset_n),
    .enable       (enable),
    .tick         (tick)
  );

  state_e           state_q, state_d;
  logic [ACC_W-1:0] acc_q, acc_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WCW-1:0]   wait_q, wait_d;
  logic             adc_conv_q, adc_conv_d;
  logic [ADC_W-1:0] sample_out_q, sample_out_d;
  logic             sample_ready_q, sample_ready_d;
  logic             rest_q, rest_d;
  logic             active_q, active_d;
  logic             overrun_q, overrun_d;
  logic [ADC_W-1:0] avg;

  assign avg = ADC_W'(acc_q >> AVG_LOG2);

  // The ack clear is applied first so a coincident publish re-asserts ready.
  always_comb begin
    state_d        = state_q;
    acc_d          = acc_q;
    cnt_d          = cnt_q;
    wait_d         = wait_q;
    sample_out_d   = sample_out_q;
    sample_ready_d = sample_ready_q;
    rest_d         = rest_q;
    active_d       = active_q;
    overrun_d      = overrun_q;

    if (ack && sample_ready_q) sample_ready_d = 1'b0;

    if (!enable) begin
      state_d = ST_IDLE;
      acc_d   = '0;
      cnt_d   = '0;
      wait_d  = '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (tick) state_d = ST_CONV;
        end
        ST_CONV: begin
          wait_d  = '0;
          state_d = (SETTLE == 0) ? ST_SAMPLE : ST_WAIT;
        end
        ST_WAIT: begin
          if (wait_q == WAIT_LAST) state_d = ST_SAMPLE;
          else                     wait_d  = wait_q + 1'b1;
        end
        ST_SAMPLE: begin
          acc_d   = acc_q + ACC_W'(adc_in);
          cnt_d   = cnt_q + 1'b1;
          state_d = (cnt_q == CNT_MAX) ? ST_PUBLISH : ST_IDLE;
        end
        ST_PUBLISH: begin
          sample_out_d   = avg;
          sample_ready_d = 1'b1;
          if (sample_ready_q && !ack) overrun_d = 1'b1;
          acc_d   = '0;
          cnt_d   = '0;
          state_d = ST_IDLE;
          if (avg >= ACTIVE_TH) begin
            active_d = 1'b1;
            rest_d   = 1'b0;
          end else if (avg < REST_TH) begin
            active_d = 1'b0;
            rest_d   = 1'b1;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end

    adc_conv_d = (state_d == ST_CONV);
  end

  always_ff @(posedge clock) begin
    if (!ctrl_reset_n) begin
      state_q        <= ST_IDLE;
      acc_q          <= '0;
      cnt_q          <= '0;
      wait_q         <= '0;
      adc_conv_q     <= 1'b0;
      sample_out_q   <= '0;
      sample_ready_q <= 1'b0;
      rest_q         <= 1'b0;
      active_q       <= 1'b0;
      overrun_q      <= 1'b0;
    end else begin
      state_q        <= state_d;
      acc_q          <= acc_d;
      cnt_q          <= cnt_d;
      wait_q         <= wait_d;
      adc_conv_q     <= adc_conv_d;
      sample_out_q   <= sample_out_d;
      sample_ready_q <= sample_ready_d;
      rest_q         <= rest_d;
      active_q       <= active_d;
      overrun_q      <= overrun_d;
    end
  end

  assign adc_conv     = adc_conv_q;
  assign sample_out   = sample_out_q;
  assign sample_ready = sample_ready_q;
  assign rest         = rest_q;
  assign active       = active_q;
  assign overrun      = overrun_q;

endmodule
